// File: rtl/bmp_slice_streamer.sv
// Holds one NSLICE x SLICE_W bitmap and streams it out on column, bottom-row and top-row valid/ready channels.
// Optional BMP_SKIP_BLANK_EN: row streams skip all-zero cross-sections using a mask captured at load.
module bmp_slice_streamer #(
    parameter int NSLICE  = 24,
    parameter int SLICE_W = 64,
    parameter int IW      = $clog2(SLICE_W > NSLICE ? SLICE_W : NSLICE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [NSLICE*SLICE_W-1:0] load_data,
    output logic                      alu_start,
    output logic [SLICE_W-1:0]        col_data,
    output logic [IW-1:0]             col_idx,
    output logic                      col_valid,
    output logic                      col_last,
    input  logic                      col_ready,
    output logic [NSLICE-1:0]         bot_data,
    output logic [IW-1:0]             bot_idx,
    output logic                      bot_valid,
    output logic                      bot_last,
    input  logic                      bot_ready,
    output logic [NSLICE-1:0]         top_data,
    output logic [IW-1:0]             top_idx,
    output logic                      top_valid,
    output logic                      top_last,
    input  logic                      top_ready,
    output logic                      all_done
);
    localparam int              BW      = NSLICE * SLICE_W;
    localparam logic [IW-1:0]   COL_END = IW'(NSLICE - 1);
    localparam logic [IW-1:0]   ROW_END = IW'(SLICE_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t r_col_st, r_bot_st, r_top_st;
    state_t w_col_st_nxt, w_bot_st_nxt, w_top_st_nxt;

    logic [BW-1:0]      r_bmp;
    logic [SLICE_W-1:0] r_col_dat;
    logic [NSLICE-1:0]  r_bot_dat, r_top_dat;
    logic [IW-1:0]      r_col_idx, r_bot_idx, r_top_idx;
    logic               r_alu_start;

    logic [IW-1:0]      w_bot_first, w_top_first, w_bot_next, w_top_next;
    logic               w_bot_more, w_top_more, w_row_any;
    logic               w_col_xfer, w_bot_xfer, w_top_xfer;

    function automatic logic [SLICE_W-1:0] get_slice(input logic [BW-1:0] bmp, input logic [IW-1:0] s);
        return bmp[int'(s)*SLICE_W +: SLICE_W];
    endfunction

    function automatic logic [NSLICE-1:0] get_row(input logic [BW-1:0] bmp, input logic [IW-1:0] b);
        logic [NSLICE-1:0] r;
        r = '0;
        for (int s = 0; s < NSLICE; s++) r[s] = bmp[s*SLICE_W + int'(b)];
        return r;
    endfunction

`ifdef BMP_SKIP_BLANK_EN
    logic [SLICE_W-1:0] r_mask, w_mask_new;
    logic               w_bot_found, w_top_found;

    // {found, index} of the lowest set bit at or above 'from'
    function automatic logic [IW:0] find_up(input logic [SLICE_W-1:0] m, input int from);
        logic [IW:0] r;
        r = '0;
        for (int i = SLICE_W - 1; i >= 0; i--)
            if (i >= from && m[i]) r = {1'b1, IW'(i)};
        return r;
    endfunction

    function automatic logic [IW:0] find_down(input logic [SLICE_W-1:0] m, input int from);
        logic [IW:0] r;
        r = '0;
        for (int i = 0; i < SLICE_W; i++)
            if (i <= from && m[i]) r = {1'b1, IW'(i)};
        return r;
    endfunction

    always_comb begin
        w_mask_new = '0;
        for (int s = 0; s < NSLICE; s++) w_mask_new = w_mask_new | load_data[s*SLICE_W +: SLICE_W];
    end

    assign {w_bot_found, w_bot_first} = find_up(w_mask_new, 0);
    assign {w_top_found, w_top_first} = find_down(w_mask_new, SLICE_W - 1);
    assign {w_bot_more, w_bot_next}   = find_up(r_mask, int'(r_bot_idx) + 1);
    assign {w_top_more, w_top_next}   = find_down(r_mask, int'(r_top_idx) - 1);
    assign w_row_any = w_bot_found & w_top_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_mask <= '0;
        else if (load) r_mask <= w_mask_new;
    end
`else
    assign w_bot_first = '0;
    assign w_top_first = ROW_END;
    assign w_bot_next  = r_bot_idx + 1'b1;
    assign w_top_next  = r_top_idx - 1'b1;
    assign w_bot_more  = (r_bot_idx != ROW_END);
    assign w_top_more  = (r_top_idx != '0);
    assign w_row_any   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_st <= S_IDLE;
            r_bot_st <= S_IDLE;
            r_top_st <= S_IDLE;
        end else begin
            r_col_st <= w_col_st_nxt;
            r_bot_st <= w_bot_st_nxt;
            r_top_st <= w_top_st_nxt;
        end
    end

    always_comb begin
        w_col_st_nxt = r_col_st;
        w_bot_st_nxt = r_bot_st;
        w_top_st_nxt = r_top_st;
        col_valid    = (r_col_st == S_STREAM);
        bot_valid    = (r_bot_st == S_STREAM);
        top_valid    = (r_top_st == S_STREAM);
        col_last     = col_valid && (r_col_idx == COL_END);
        bot_last     = bot_valid && !w_bot_more;
        top_last     = top_valid && !w_top_more;
        w_col_xfer   = col_valid && col_ready;
        w_bot_xfer   = bot_valid && bot_ready;
        w_top_xfer   = top_valid && top_ready;
        all_done     = (r_col_st == S_DONE) && (r_bot_st == S_DONE) && (r_top_st == S_DONE);
        // load outranks any handshake in the same cycle
        if (load) begin
            w_col_st_nxt = S_STREAM;
            w_bot_st_nxt = w_row_any ? S_STREAM : S_DONE;
            w_top_st_nxt = w_row_any ? S_STREAM : S_DONE;
        end else begin
            if (w_col_xfer && col_last) w_col_st_nxt = S_DONE;
            if (w_bot_xfer && bot_last) w_bot_st_nxt = S_DONE;
            if (w_top_xfer && top_last) w_top_st_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bmp       <= '0;
            r_alu_start <= 1'b0;
            r_col_idx   <= '0;
            r_bot_idx   <= '0;
            r_top_idx   <= ROW_END;
            r_col_dat   <= '0;
            r_bot_dat   <= '0;
            r_top_dat   <= '0;
        end else begin
            r_alu_start <= load;
            if (load) begin
                r_bmp     <= load_data;
                r_col_idx <= '0;
                r_col_dat <= get_slice(load_data, '0);
                r_bot_idx <= w_bot_first;
                r_bot_dat <= get_row(load_data, w_bot_first);
                r_top_idx <= w_top_first;
                r_top_dat <= get_row(load_data, w_top_first);
            end else begin
                if (w_col_xfer && !col_last) begin
                    r_col_idx <= r_col_idx + 1'b1;
                    r_col_dat <= get_slice(r_bmp, r_col_idx + 1'b1);
                end
                if (w_bot_xfer && !bot_last) begin
                    r_bot_idx <= w_bot_next;
                    r_bot_dat <= get_row(r_bmp, w_bot_next);
                end
                if (w_top_xfer && !top_last) begin
                    r_top_idx <= w_top_next;
                    r_top_dat <= get_row(r_bmp, w_top_next);
                end
            end
        end
    end

    assign alu_start = r_alu_start;
    assign col_data  = r_col_dat;
    assign col_idx   = r_col_idx;
    assign bot_data  = r_bot_dat;
    assign bot_idx   = r_bot_idx;
    assign top_data  = r_top_dat;
    assign top_idx   = r_top_idx;

endmodule

// File: tb/tb_bmp_slice_streamer.sv
// Directed bench for bmp_slice_streamer: a 24x64 instance and a 4x8 instance, expectations built from the loaded pattern.
module tb_bmp_slice_streamer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef BMP_SKIP_BLANK_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          b_load = 1'b0, b_alu, b_cv, b_cl, b_cr = 1'b1, b_bv, b_bl, b_br = 1'b1;
    logic          b_tv, b_tl, b_tr = 1'b1, b_done;
    logic [1535:0] b_ld = '0;
    logic [63:0]   b_cd;
    logic [23:0]   b_bd, b_td;
    logic [5:0]    b_ci, b_bi, b_ti;

    logic          s_load = 1'b0, s_alu, s_cv, s_cl, s_cr = 1'b1, s_bv, s_bl, s_br = 1'b1;
    logic          s_tv, s_tl, s_tr = 1'b1, s_done;
    logic [31:0]   s_ld = '0;
    logic [7:0]    s_cd;
    logic [3:0]    s_bd, s_td;
    logic [2:0]    s_ci, s_bi, s_ti;

    bmp_slice_streamer #(.NSLICE(24), .SLICE_W(64)) u_big (
        .clk(clk), .rst_n(rst_n), .load(b_load), .load_data(b_ld), .alu_start(b_alu),
        .col_data(b_cd), .col_idx(b_ci), .col_valid(b_cv), .col_last(b_cl), .col_ready(b_cr),
        .bot_data(b_bd), .bot_idx(b_bi), .bot_valid(b_bv), .bot_last(b_bl), .bot_ready(b_br),
        .top_data(b_td), .top_idx(b_ti), .top_valid(b_tv), .top_last(b_tl), .top_ready(b_tr),
        .all_done(b_done)
    );

    bmp_slice_streamer #(.NSLICE(4), .SLICE_W(8)) u_small (
        .clk(clk), .rst_n(rst_n), .load(s_load), .load_data(s_ld), .alu_start(s_alu),
        .col_data(s_cd), .col_idx(s_ci), .col_valid(s_cv), .col_last(s_cl), .col_ready(s_cr),
        .bot_data(s_bd), .bot_idx(s_bi), .bot_valid(s_bv), .bot_last(s_bl), .bot_ready(s_br),
        .top_data(s_td), .top_idx(s_ti), .top_valid(s_tv), .top_last(s_tl), .top_ready(s_tr),
        .all_done(s_done)
    );

    // slice s = {40'h0, s, s, s} (bytes), optionally inverted
    function automatic logic [63:0] big_slice(input int s, input bit inv);
        logic [7:0]  v;
        logic [63:0] r;
        v = 8'(s);
        r = {40'h0, v, v, v};
        return inv ? ~r : r;
    endfunction

    function automatic logic [1535:0] big_bmp(input bit inv);
        logic [1535:0] r;
        for (int s = 0; s < 24; s++) r[s*64 +: 64] = big_slice(s, inv);
        return r;
    endfunction

    function automatic logic [23:0] big_row(input int b, input bit inv);
        logic [23:0] r;
        logic [63:0] t;
        for (int s = 0; s < 24; s++) begin
            t = big_slice(s, inv);
            r[s] = t[b];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic big_load(input logic [1535:0] d);
        b_ld = d;
        b_load = 1'b1;
        tick();
        b_load = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        @(negedge clk);
        tests_run++;
        if ({b_cv, b_bv, b_tv, b_cl, b_bl, b_tl, b_alu, b_done} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 00000000", {b_cv, b_bv, b_tv, b_cl, b_bl, b_tl, b_alu, b_done});
        end
        tests_run++;
        if ({b_ci, b_bi, b_ti, s_ti} !== {6'd0, 6'd0, 6'd63, 3'd7}) begin
            tests_failed++;
            $display("FAIL reset_idx got %h want %h", {b_ci, b_bi, b_ti, s_ti}, {6'd0, 6'd0, 6'd63, 3'd7});
        end
        tests_run++;
        if ({b_cd, b_bd, b_td} !== 112'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h want 0", {b_cd, b_bd, b_td});
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if ({b_cv, b_bv, b_tv, s_cv} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL idle_no_valid got %b want 0000", {b_cv, b_bv, b_tv, s_cv});
        end
    endtask

    task automatic test_full_stream();
        b_cr = 1'b1; b_br = 1'b1; b_tr = 1'b1;
        big_load(big_bmp(1'b0));
        for (int k = 0; k < 66; k++) begin
            @(negedge clk);
            tests_run++;
            if ({b_alu, b_done} !== {k == 0, k >= 64}) begin
                tests_failed++;
                $display("FAIL full_alu_done k=%0d got %b want %b", k, {b_alu, b_done}, {k == 0, k >= 64});
            end
            tests_run++;
            if ({b_cv, b_ci, b_cl} !== ((k < 24) ? {1'b1, 6'(k), k == 23} : {1'b0, 6'd23, 1'b0})) begin
                tests_failed++;
                $display("FAIL full_col k=%0d got v%b i%0d l%b", k, b_cv, b_ci, b_cl);
            end
            if (k < 24) begin
                tests_run++;
                if (b_cd !== big_slice(k, 1'b0)) begin
                    tests_failed++;
                    $display("FAIL full_col_data k=%0d got %h want %h", k, b_cd, big_slice(k, 1'b0));
                end
            end
            tests_run++;
            if ({b_bv, b_bi, b_bl} !== ((k < 64) ? {1'b1, 6'(k), k == 63} : {1'b0, 6'd63, 1'b0})) begin
                tests_failed++;
                $display("FAIL full_bot k=%0d got v%b i%0d l%b", k, b_bv, b_bi, b_bl);
            end
            tests_run++;
            if ({b_tv, b_ti, b_tl} !== ((k < 64) ? {1'b1, 6'(63 - k), k == 63} : {1'b0, 6'd0, 1'b0})) begin
                tests_failed++;
                $display("FAIL full_top k=%0d got v%b i%0d l%b", k, b_tv, b_ti, b_tl);
            end
            if (k < 64) begin
                tests_run++;
                if ({b_bd, b_td} !== {big_row(k, 1'b0), big_row(63 - k, 1'b0)}) begin
                    tests_failed++;
                    $display("FAIL full_row_data k=%0d got %h want %h", k, {b_bd, b_td},
                             {big_row(k, 1'b0), big_row(63 - k, 1'b0)});
                end
            end
        end
    endtask

    task automatic test_col_backpressure();
        int got = 0;
        b_cr = 1'b1;
        big_load(big_bmp(1'b0));
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            tests_run++;
            if ({b_cv, b_ci, b_cl} !== ((got < 24) ? {1'b1, 6'(got), got == 23} : {1'b0, 6'd23, 1'b0})) begin
                tests_failed++;
                $display("FAIL bp_col c=%0d got v%b i%0d l%b want beat %0d", c, b_cv, b_ci, b_cl, got);
            end
            if (b_cv && b_cr) got++;
            tick();
            b_cr = ~b_cr;
        end
        tests_run++;
        if (got !== 24) begin
            tests_failed++;
            $display("FAIL bp_beat_count got %0d want 24", got);
        end
        b_cr = 1'b1;
    endtask

    task automatic test_load_midstream();
        b_cr = 1'b1; b_br = 1'b1; b_tr = 1'b1;
        big_load(big_bmp(1'b0));
        for (int c = 0; c < 10; c++) begin
            b_br = (c < 5);
            tick();
        end
        @(negedge clk);
        tests_run++;
        if ({b_ci, b_bi, b_done} !== {6'd10, 6'd5, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_pre_idx got c%0d b%0d want c10 b5", b_ci, b_bi);
        end
        b_br = 1'b1;
        big_load(big_bmp(1'b1));
        @(negedge clk);
        tests_run++;
        if ({b_cv, b_ci, b_bv, b_bi, b_tv, b_ti, b_alu, b_done} !== {1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd63, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_restart got c%0d b%0d t%0d alu%b done%b", b_ci, b_bi, b_ti, b_alu, b_done);
        end
        tests_run++;
        if ({b_cd, b_bd} !== {big_slice(0, 1'b1), big_row(0, 1'b1)}) begin
            tests_failed++;
            $display("FAIL mid_new_data got %h want %h", {b_cd, b_bd}, {big_slice(0, 1'b1), big_row(0, 1'b1)});
        end
        big_load(big_bmp(1'b0));
        @(negedge clk);
        tests_run++;
        if ({b_alu, b_ci, b_ti, b_cd} !== {1'b1, 6'd0, 6'd63, big_slice(0, 1'b0)}) begin
            tests_failed++;
            $display("FAIL reload_alu got alu%b c%0d t%0d", b_alu, b_ci, b_ti);
        end
        @(negedge clk);
        tests_run++;
        if ({b_alu, b_ci, b_ti} !== {1'b0, 6'd1, 6'd62}) begin
            tests_failed++;
            $display("FAIL reload_step got alu%b c%0d t%0d want alu0 c1 t62", b_alu, b_ci, b_ti);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({b_cv, b_bv, b_tv, b_done, b_ti, b_ci} !== {4'b0000, 6'd63, 6'd0}) begin
            tests_failed++;
            $display("FAIL rst_mid got v%b%b%b done%b t%0d c%0d", b_cv, b_bv, b_tv, b_done, b_ti, b_ci);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        tests_run++;
        if ({b_cv, b_cd} !== 65'h0) begin
            tests_failed++;
            $display("FAIL rst_no_retain got v%b d%h want 0", b_cv, b_cd);
        end
    endtask

    task automatic test_small_geometry();
        logic [31:0] pats [2];
        pats[0] = 32'hFFFF_FFFF;
        pats[1] = {8'h24, 8'h00, 8'h20, 8'h04};
        for (int p = 0; p < 2; p++) begin
            logic [7:0] sl [4];
            logic [7:0] mask;
            logic [3:0] row;
            int bexp[$];
            int nrow, tk;
            mask = '0;
            for (int s = 0; s < 4; s++) begin
                sl[s] = pats[p][s*8 +: 8];
                mask = mask | sl[s];
            end
            bexp.delete();
            for (int b = 0; b < 8; b++) if (!SKIP || mask[b]) bexp.push_back(b);
            nrow = bexp.size();
            s_ld = pats[p];
            s_load = 1'b1;
            tick();
            s_load = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                tests_run++;
                if ({s_cv, s_ci, s_cl} !== ((k < 4) ? {1'b1, 3'(k), k == 3} : {1'b0, 3'd3, 1'b0})) begin
                    tests_failed++;
                    $display("FAIL small_col p=%0d k=%0d got v%b i%0d l%b", p, k, s_cv, s_ci, s_cl);
                end
                if (k < 4) begin
                    tests_run++;
                    if (s_cd !== sl[k]) begin
                        tests_failed++;
                        $display("FAIL small_col_data p=%0d k=%0d got %h want %h", p, k, s_cd, sl[k]);
                    end
                end
                if (k < nrow) begin
                    for (int s = 0; s < 4; s++) row[s] = sl[s][bexp[k]];
                    tests_run++;
                    if ({s_bv, s_bi, s_bl, s_bd} !== {1'b1, 3'(bexp[k]), k == nrow - 1, row}) begin
                        tests_failed++;
                        $display("FAIL small_bot p=%0d k=%0d got i%0d l%b d%h want i%0d d%h",
                                 p, k, s_bi, s_bl, s_bd, bexp[k], row);
                    end
                    tk = bexp[nrow - 1 - k];
                    for (int s = 0; s < 4; s++) row[s] = sl[s][tk];
                    tests_run++;
                    if ({s_tv, s_ti, s_tl, s_td} !== {1'b1, 3'(tk), k == nrow - 1, row}) begin
                        tests_failed++;
                        $display("FAIL small_top p=%0d k=%0d got i%0d l%b d%h want i%0d d%h",
                                 p, k, s_ti, s_tl, s_td, tk, row);
                    end
                end else begin
                    tests_run++;
                    if ({s_bv, s_tv} !== 2'b00) begin
                        tests_failed++;
                        $display("FAIL small_row_end p=%0d k=%0d got %b want 00", p, k, {s_bv, s_tv});
                    end
                end
                tests_run++;
                if (s_done !== (k >= ((nrow > 4) ? nrow : 4))) begin
                    tests_failed++;
                    $display("FAIL small_done p=%0d k=%0d got %b", p, k, s_done);
                end
            end
        end
    endtask

    task automatic test_blank_bitmap();
        int done_at;
        done_at = SKIP ? 24 : 64;
        big_load('0);
        for (int k = 0; k < 67; k++) begin
            @(negedge clk);
            tests_run++;
            if ({b_alu, b_cv, b_bv, b_tv, b_done} !==
                {k == 0, k < 24, !SKIP && k < 64, !SKIP && k < 64, k >= done_at}) begin
                tests_failed++;
                $display("FAIL blank k=%0d got alu%b c%b b%b t%b done%b", k, b_alu, b_cv, b_bv, b_tv, b_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_col_backpressure();
        test_load_midstream();
        test_reset_midstream();
        test_small_geometry();
        test_blank_bitmap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
